// File: rtl/screen_timing.sv
// Raster timing generator: free-running sy:sx beam counter with sync and
// data-enable flags decoded combinationally from the same registered position.
module screen_timing #(
    parameter int CORDW    = 10,
    parameter int H_RES    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_RES    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    output logic [CORDW-1:0] sx_out,
    output logic [CORDW-1:0] sy_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             de_out
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);
    localparam logic             SYNC_ACT = (SYNC_POL != 0);

    logic [CORDW-1:0] r_sx;
    logic [CORDW-1:0] r_sy;
    logic             w_line_end;
    logic             w_frame_end;
    logic             w_hs_act;
    logic             w_vs_act;

    assign w_line_end  = (r_sx == H_LAST);
    assign w_frame_end = (r_sy == V_LAST);

    // Reset wins over counting, so a mid-frame reset restarts the raster at (0,0).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sx <= '0;
            r_sy <= '0;
        end else if (w_line_end) begin
            r_sx <= '0;
            r_sy <= w_frame_end ? '0 : r_sy + 1'b1;
        end else begin
            r_sx <= r_sx + 1'b1;
        end
    end

    assign w_hs_act = (r_sx >= HS_START) && (r_sx < HS_END);
    assign w_vs_act = (r_sy >= VS_START) && (r_sy < VS_END);

    assign sx_out    = r_sx;
    assign sy_out    = r_sy;
    assign hsync_out = w_hs_act ? SYNC_ACT : ~SYNC_ACT;
    assign vsync_out = w_vs_act ? SYNC_ACT : ~SYNC_ACT;
    assign de_out    = (r_sx < H_ACT) && (r_sy < V_ACT);

endmodule

// File: tb/tb_screen_timing.sv
// Directed bench: full-size 640x480 instance for reset, line wrap, hsync window and
// mid-line reset; a shrunken-timing instance for vertical timing and whole-frame counts.
module tb_screen_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance (default parameters).
    logic       rst_a;
    logic [9:0] sx_a, sy_a;
    logic       hs_a, vs_a, de_a;

    screen_timing u_a (
        .clk_in(clk), .rst_in(rst_a), .sx_out(sx_a), .sy_out(sy_a),
        .hsync_out(hs_a), .vsync_out(vs_a), .de_out(de_a)
    );

    // Small instance: H 16+2+4+3 = 25, V 12+2+2+3 = 19, frame = 475 clocks.
    // hsync at sx 18..21, vsync at sy 14..15, frame boundary at (12,0).
    logic       rst_b;
    logic [9:0] sx_b, sy_b;
    logic       hs_b, vs_b, de_b;

    screen_timing #(
        .CORDW(10), .H_RES(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_RES(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(0)
    ) u_b (
        .clk_in(clk), .rst_in(rst_b), .sx_out(sx_b), .sy_out(sy_b),
        .hsync_out(hs_b), .vsync_out(vs_b), .de_out(de_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until the given position is reached (or the budget runs out), then check it.
    task automatic wait_a(input int y, input int x, input int budget, input string tag);
        int n = 0;
        while (!(int'(sy_a) == y && int'(sx_a) == x) && n < budget) begin
            step();
            n++;
        end
        chk(tag, int'(sy_a) * 1000 + int'(sx_a), y * 1000 + x);
    endtask

    task automatic wait_b(input int y, input int x, input int budget, input string tag);
        int n = 0;
        while (!(int'(sy_b) == y && int'(sx_b) == x) && n < budget) begin
            step();
            n++;
        end
        chk(tag, int'(sy_b) * 1000 + int'(sx_b), y * 1000 + x);
    endtask

    // Count flags over one full small frame starting at the current (0,0) sample.
    task automatic frame_counts_b(input string tag);
        int n_de = 0, n_hs = 0, n_vs = 0, n_fb = 0;
        for (int i = 0; i < 475; i++) begin
            if (de_b) n_de++;
            if (!hs_b) n_hs++;
            if (!vs_b) n_vs++;
            if (sy_b == 10'd12 && sx_b == 10'd0) n_fb++;
            step();
        end
        chk({tag, "_de"},   n_de, 192);
        chk({tag, "_hs"},   n_hs, 76);
        chk({tag, "_vs"},   n_vs, 50);
        chk({tag, "_fb"},   n_fb, 1);
        chk({tag, "_wrap"}, int'(sy_b) * 1000 + int'(sx_b), 0);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst_sx", int'(sx_a), 0);
        chk("rst_sy", int'(sy_a), 0);
        chk("rst_de", int'(de_a), 1);
        chk("rst_hs", int'(hs_a), 1);
        chk("rst_vs", int'(vs_a), 1);
        chk("rst_b_pos", int'(sy_b) * 1000 + int'(sx_b), 0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        step();
        chk("first_sx", int'(sx_a), 1);
        chk("first_sy", int'(sy_a), 0);

        // Active edge and hsync window on line 0
        wait_a(0, 639, 1000, "pos_639");
        chk("de_639", int'(de_a), 1);
        step();
        chk("de_640", int'(de_a), 0);
        wait_a(0, 655, 1000, "pos_655");
        chk("hs_655", int'(hs_a), 1);
        step();
        chk("hs_656", int'(hs_a), 0);
        wait_a(0, 751, 1000, "pos_751");
        chk("hs_751", int'(hs_a), 0);
        chk("vs_line0", int'(vs_a), 1);
        step();
        chk("hs_752", int'(hs_a), 1);

        // Line wrap
        wait_a(10, 799, 10000, "pos_10_799");
        step();
        chk("wrap_sx", int'(sx_a), 0);
        chk("wrap_sy", int'(sy_a), 11);

        // Mid-line reset on the full-size instance
        wait_a(11, 400, 1000, "pos_11_400");
        rst_a = 1'b1;
        step();
        chk("mrst_pos", int'(sy_a) * 1000 + int'(sx_a), 0);
        chk("mrst_de", int'(de_a), 1);
        rst_a = 1'b0;
        step();
        chk("mrst_resume", int'(sy_a) * 1000 + int'(sx_a), 1);

        // Vertical timing on the small instance
        wait_b(12, 0, 1000, "b_pos_12_0");
        chk("b_de_12_0", int'(de_b), 0);
        wait_b(13, 24, 1000, "b_pos_13_24");
        chk("b_vs_13_24", int'(vs_b), 1);
        step();
        chk("b_vs_14_0", int'(vs_b), 0);
        wait_b(15, 24, 1000, "b_pos_15_24");
        chk("b_vs_15_24", int'(vs_b), 0);
        step();
        chk("b_vs_16_0", int'(vs_b), 1);
        wait_b(18, 24, 1000, "b_pos_18_24");
        step();
        chk("b_frame_wrap", int'(sy_b) * 1000 + int'(sx_b), 0);

        // Whole-frame counts after a cold reset
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        frame_counts_b("cold");

        // Mid-frame reset, then the next frame must match a cold start
        wait_b(9, 10, 1000, "b_pos_9_10");
        rst_b = 1'b1;
        step();
        chk("b_mrst_pos", int'(sy_b) * 1000 + int'(sx_b), 0);
        rst_b = 1'b0;
        frame_counts_b("warm");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
